fir_out_requant: RTL and testbench
==================================

Name: fir_out_requant

Overview:
- Downstream stage of the FIR filter IP.
- Consumes the filter's 32-bit AXI-Stream output, which has no tready and so can never be stalled.
- Rounds and arithmetic-shifts each result, saturates it to 16 bits, and buffers it in a FIFO that drives a backpressure-capable AXI-Stream output toward DAC/capture logic.
- Reports saturation events and FIFO overflow.

Parameters:
- IN_W, 32, input sample width (two's complement).
- OUT_W, 16, output sample width (two's complement).
- SHIFT, 15, right-shift amount (coefficient Q-format); legal range 1..IN_W-OUT_W+1.
- FIFO_DEPTH, 16, FIFO capacity in samples; must be a power of two.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- s_axis_tvalid  in  1  input sample valid; the upstream side has no tready.
- s_axis_tdata  in  IN_W  signed filter output.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  OUT_W  signed requantised sample.
- clr_flags  in  1  synchronous clear of ovf_flag and sat_cnt.
- ovf_flag  out  1  sticky: a sample was dropped because the FIFO was full.
- sat_cnt  out  16  count of saturated samples; holds at 0xFFFF.
- fill_level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Clock and reset: single clock domain on clk. rst_n is asynchronous, active-low.
- Reset state:
  - Pipeline valids, FIFO pointers and fill_level are 0.
  - m_axis_tvalid=0, m_axis_tdata=0, ovf_flag=0, sat_cnt=0.
  - Reset asserted mid-operation discards all in-flight and buffered samples; m_axis_tvalid falls immediately.
- Stage 1 (registered): sum = sext(s_axis_tdata, IN_W+1) + 2^(SHIFT-1).
  - Rounding is round-half-up.
  - The extra bit prevents wrap at the positive full-scale input.
- Stage 2 (registered):
  - q = sum >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, output 0x7FFF; if q < -2^(OUT_W-1), output 0x8000; otherwise output q[OUT_W-1:0].
  - A saturating sample increments sat_cnt, unless sat_cnt is already 0xFFFF.
- FIFO write: when stage-2 valid is set, the sample is written at the next edge.
- Latency: a sample accepted at edge N appears with m_axis_tvalid=1 after edge N+3, given an empty FIFO.
- Output handshake:
  - A transfer occurs on an edge where m_axis_tvalid && m_axis_tready.
  - m_axis_tdata is the FIFO head and stays stable while tvalid=1 and tready=0.
  - m_axis_tvalid = (fill_level != 0), registered.
  - Samples leave in arrival order.
- Full FIFO:
  - If fill_level=FIFO_DEPTH and a write is pending with no same-cycle read, the sample is dropped and ovf_flag is set.
  - Simultaneous read and write when full is accepted: no drop, fill_level unchanged.
- Empty FIFO: a read is impossible. A simultaneous write and read at fill_level=1 leaves fill_level=1.
- Pointers: ADDR_W bits, wrapping naturally. fill_level is tracked by a separate up/down counter.
- clr_flags: clears ovf_flag and sat_cnt on the next edge. If a saturation or drop occurs in the same cycle, the clear wins and that event is lost.
- Back-to-back input is supported: one sample per clock, continuously.
- Implementation is fully synchronous apart from the reset. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: REQUANT_CONVERGENT_EN.
- Defined: stage 1 uses round-half-to-even.
  - Exact ties (the discarded bits equal 2^(SHIFT-1)) round to the even q.
  - Non-tie behaviour is identical to round-half-up.
  - Latency is unchanged.
- Undefined: round-half-up, as specified in Behaviour.

Test Plan:
- Rounding, macro undefined (SHIFT=15, m_axis_tready=1): inputs 0x00003FFF, 0x00004000, 0x0000C000 -> outputs 0x0000, 0x0001, 0x0002. The first output has m_axis_tvalid high exactly 3 edges after input.
- Convergent rounding (REQUANT_CONVERGENT_EN defined): inputs 0x00004000, 0x0000C000, 0x00004001 -> outputs 0x0000, 0x0002, 0x0001.
- Saturation: inputs 0x40000000, 0xC0000000, 0xBFFF0000, 0x7FFFFFFF -> outputs 0x7FFF, 0x8000, 0x8000, 0x7FFF; sat_cnt=3, since 0xC0000000 is exact and not saturated. Then pulse clr_flags -> sat_cnt=0.
- Overflow (m_axis_tready=0): 20 consecutive samples 1..20 (scaled by 2^15) -> fill_level=16 and ovf_flag=1. Then raise tready -> exactly 16 outputs 0x0001..0x0010 in order, then m_axis_tvalid=0 and fill_level=0.
- Full with simultaneous read: FIFO full, tready=1, continuous input -> no drops, ovf_flag stays 0, fill_level stays 16, output stream gap-free.
- Reset mid-stream: assert rst_n low while the FIFO holds 8 samples -> m_axis_tvalid=0, fill_level=0 and sat_cnt=0 immediately, with no stale sample after release.

Source files
------------

// File: rtl/fir_out_requant.sv
// Requantises the 32-bit FIR output: round, arithmetic shift, saturate to OUT_W bits, then buffer in a FIFO.
// Optional REQUANT_CONVERGENT_EN selects round-half-to-even instead of round-half-up.
module fir_out_requant #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  input  logic [IN_W-1:0]  s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  input  logic             clr_flags,
  output logic             ovf_flag,
  output logic [15:0]      sat_cnt,
  output logic [ADDR_W:0]  fill_level
);
  localparam int SUM_W = IN_W + 1;
  localparam int Q_W   = SUM_W - SHIFT;
  localparam logic [SUM_W-1:0]      HALF     = SUM_W'(1) << (SHIFT - 1);
  localparam logic [SUM_W-1:0]      HALF_M1  = HALF - SUM_W'(1);
  localparam logic signed [Q_W-1:0] Q_MAX    = Q_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [Q_W-1:0] Q_MIN    = -Q_MAX - Q_W'(1);
  localparam logic [OUT_W-1:0]      O_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      O_MIN    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ADDR_W:0]       FULL_LVL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]       ONE_LVL  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]     ONE_PTR  = ADDR_W'(1);

  logic                    s1_vld_q;
  logic [SUM_W-1:0]        s1_sum_q, s1_sum_d, round_add;
  logic                    s2_vld_q;
  logic [OUT_W-1:0]        s2_data_q, s2_data_d;
  logic signed [Q_W-1:0]   q;
  logic                    sat;

  logic [OUT_W-1:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]         fill_q, fill_d, avail;
  logic                    rd_fire, full, wr_en, drop;
  logic                    tvalid_q;
  logic [OUT_W-1:0]        tdata_q, tdata_d;
  logic                    ovf_q;
  logic [15:0]             sat_cnt_q;

  // Stage 1: sign-extend by one bit so the rounding add cannot wrap at positive full scale.
  always_comb begin
    round_add = HALF;
`ifdef REQUANT_CONVERGENT_EN
    // Exact tie with an even floor: add one less than half so the result stays on the even value.
    if (s_axis_tdata[SHIFT-1:0] == HALF[SHIFT-1:0] && !s_axis_tdata[SHIFT])
      round_add = HALF_M1;
`endif
    s1_sum_d = {s_axis_tdata[IN_W-1], s_axis_tdata} + round_add;
  end

  always_comb begin
    q         = $signed(s1_sum_q[SUM_W-1:SHIFT]);
    sat       = 1'b0;
    s2_data_d = q[OUT_W-1:0];
    if (q > Q_MAX) begin
      sat       = 1'b1;
      s2_data_d = O_MAX;
    end else if (q < Q_MIN) begin
      sat       = 1'b1;
      s2_data_d = O_MIN;
    end
  end

  // A sample written this edge becomes visible one edge later; reads retire immediately.
  always_comb begin
    rd_fire  = tvalid_q && m_axis_tready;
    full     = (fill_q == FULL_LVL);
    wr_en    = s2_vld_q && (!full || rd_fire);
    drop     = s2_vld_q && full && !rd_fire;
    wr_ptr_d = wr_en ? wr_ptr_q + ONE_PTR : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + ONE_PTR : rd_ptr_q;
    avail    = rd_fire ? fill_q - ONE_LVL : fill_q;
    fill_d   = fill_q;
    if (wr_en && !rd_fire) fill_d = fill_q + ONE_LVL;
    else if (!wr_en && rd_fire) fill_d = fill_q - ONE_LVL;
    tdata_d = tdata_q;
    if (avail != '0) tdata_d = mem[rd_ptr_d];
    else if (wr_en)  tdata_d = s2_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sum_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      ovf_q     <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      s1_vld_q <= s_axis_tvalid;
      if (s_axis_tvalid) s1_sum_q <= s1_sum_d;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_data_q <= s2_data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      tvalid_q <= (avail != '0);
      tdata_q  <= tdata_d;
      if (clr_flags) begin
        ovf_q     <= 1'b0;
        sat_cnt_q <= '0;
      end else begin
        if (drop) ovf_q <= 1'b1;
        if (s1_vld_q && sat && sat_cnt_q != '1) sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= s2_data_q;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign ovf_flag      = ovf_q;
  assign sat_cnt       = sat_cnt_q;
  assign fill_level    = fill_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: vector table, hand-written corner sequences, randomized scoreboard.
module tb_fir_out_requant;
  localparam int IN_W = 32, OUT_W = 16, SHIFT = 15, DEPTH = 16, ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic [IN_W-1:0]   s_axis_tdata = '0;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic              clr_flags = 1'b0;
  logic              ovf_flag;
  logic [15:0]       sat_cnt;
  logic [ADDR_W:0]   fill_level;

  always #5 clk = ~clk;

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .clr_flags(clr_flags), .ovf_flag(ovf_flag), .sat_cnt(sat_cnt), .fill_level(fill_level)
  );

  typedef struct { logic [31:0] din; logic [15:0] dout; } vec_t;
  vec_t        tbl [9];
  int          checks = 0, failures = 0, rx_cnt = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observes the handshake before the edge, then advances to the next falling edge.
  task automatic tick();
    if (m_axis_tvalid && m_axis_tready) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected no output", m_axis_tdata);
      end else begin
        chk("out_data", m_axis_tdata, exp_q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  // Reference: floor division plus remainder decides rounding, then clamp.
  function automatic logic [16:0] ref_rq(input logic [31:0] x);
    longint v, fl, rem, qv;
    v   = longint'($signed(x));
    fl  = v >>> SHIFT;
    rem = v - fl * (longint'(1) << SHIFT);
    if (rem > (longint'(1) << (SHIFT - 1)))      qv = fl + 1;
    else if (rem < (longint'(1) << (SHIFT - 1))) qv = fl;
    else begin
`ifdef REQUANT_CONVERGENT_EN
      qv = ((fl & 1) == 0) ? fl : fl + 1;
`else
      qv = fl + 1;
`endif
    end
    if (qv > 32767)       return {1'b1, 16'h7FFF};
    else if (qv < -32768) return {1'b1, 16'h8000};
    else                  return {1'b0, qv[15:0]};
  endfunction

  task automatic send(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] corner [6];
    logic [31:0] d;
    logic [16:0] r;
    int          rx0, sat_exp;

    tbl[0] = '{32'h0000_3FFF, 16'h0000};
`ifdef REQUANT_CONVERGENT_EN
    tbl[1] = '{32'h0000_4000, 16'h0000};
    tbl[4] = '{32'hFFFF_4000, 16'hFFFE};
`else
    tbl[1] = '{32'h0000_4000, 16'h0001};
    tbl[4] = '{32'hFFFF_4000, 16'hFFFF};
`endif
    tbl[2] = '{32'h0000_C000, 16'h0002};
    tbl[3] = '{32'h0000_4001, 16'h0001};
    tbl[5] = '{32'h4000_0000, 16'h7FFF};
    tbl[6] = '{32'hC000_0000, 16'h8000};
    tbl[7] = '{32'hBFFF_0000, 16'h8000};
    tbl[8] = '{32'h7FFF_FFFF, 16'h7FFF};
    corner = '{32'h3FFF_8000, 32'h3FFF_BFFF, 32'h3FFF_C000, 32'hC000_0000, 32'hBFFF_C000, 32'hBFFF_BFFF};

    repeat (3) @(negedge clk);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_fill", fill_level, 0);
    chk("reset_ovf", ovf_flag, 0);
    chk("reset_sat", sat_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table, back-to-back, with first-sample latency check.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = tbl[i].din;
      exp_q.push_back(tbl[i].dout);
      tick();
      if (i == 2) chk("latency_edge2_tvalid", m_axis_tvalid, 0);
      if (i == 3) chk("latency_edge3_tvalid", m_axis_tvalid, 1);
    end
    drain();
    chk("table_sat_cnt", sat_cnt, 3);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_sat_cnt", sat_cnt, 0);

    // Clear coinciding with a saturation event: the clear wins.
    send(32'h7FFF_FFFF);
    exp_q.push_back(16'h7FFF);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_wins_sat", sat_cnt, 0);
    drain();

    // Overflow: 20 samples into a stalled FIFO.
    m_axis_tready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(k) << SHIFT;
      tick();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    chk("ovf_fill", fill_level, 16);
    chk("ovf_flag", ovf_flag, 1);
    chk("ovf_tvalid", m_axis_tvalid, 1);
    chk("ovf_head_stable", m_axis_tdata, 16'h0001);
    for (int k = 1; k <= 16; k++) exp_q.push_back(16'(k));
    rx0 = rx_cnt;
    drain();
    chk("ovf_rx_count", rx_cnt - rx0, 16);
    chk("ovf_drained_tvalid", m_axis_tvalid, 0);
    chk("ovf_drained_fill", fill_level, 0);
    chk("ovf_sticky", ovf_flag, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_cleared", ovf_flag, 0);

    // Full FIFO with reads starting exactly when the 17th sample arrives.
    m_axis_tready = 1'b0;
    for (int j = 0; j < 50; j++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(j + 1) << SHIFT;
      exp_q.push_back(16'(j + 1));
      if (j >= 18) m_axis_tready = 1'b1;
      tick();
      if (j >= 17) begin
        chk("full_rw_fill", fill_level, 16);
        chk("full_rw_tvalid", m_axis_tvalid, 1);
      end
    end
    drain();
    chk("full_rw_ovf", ovf_flag, 0);

    // Reset while 8 samples are buffered.
    m_axis_tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (k == 0) ? 32'h7FFF_FFFF : 32'(k) << SHIFT;
      tick();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    chk("prerst_fill", fill_level, 8);
    chk("prerst_sat", sat_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_sat", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    repeat (10) tick();
    chk("postrst_tvalid", m_axis_tvalid, 0);

    // Randomized traffic against the reference model; outstanding kept below FIFO depth.
    sat_exp = 0;
    for (int c = 0; c < 600; c++) begin
      m_axis_tready = ($urandom % 4) != 0;
      if (($urandom % 2) == 1 && exp_q.size() < 12) begin
        case ($urandom % 4)
          0:       d = $urandom;
          1:       d = 32'((int'($urandom_range(0, 65535)) - 32768) * 32768 + 16384);
          2:       d = 32'(int'($urandom_range(0, 2097152)) - 1048576);
          default: d = corner[$urandom_range(0, 5)];
        endcase
        r = ref_rq(d);
        exp_q.push_back(r[15:0]);
        if (r[16]) sat_exp++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      tick();
    end
    drain();
    chk("rand_sat_cnt", sat_cnt, sat_exp);
    chk("rand_ovf", ovf_flag, 0);
    chk("rand_fill", fill_level, 0);
    chk("rand_tvalid", m_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
